// File: rtl/modinv_pkg.sv
// Shared types and constants for the binary extended-Euclid modular inverter.
package modinv_pkg;

    localparam int MODINV_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        HALVE_U,
        HALVE_V,
        SUB,
        DONE
    } modinv_state_e;

endpackage

// File: rtl/modinv_half.sv
// Combinational x/2 mod p for odd p: adds p when x is odd, then drops the LSB of the W+1-bit sum.
module modinv_half #(
    parameter int W = 256
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] p,
    output logic [W-1:0] y
);

    logic [W:0] sum;

    assign sum = {1'b0, x} + (x[0] ? {1'b0, p} : {(W+1){1'b0}});
    assign y   = sum[W:1];

endmodule

// File: rtl/modinv_bin.sv
// Binary extended-Euclid inverter b = a^-1 mod p, one step per clock, start/done handshake.
// Optional argument check on start is built when MODINV_ARGCHK_EN is defined.
//
// Handshake: start is sampled only in IDLE; busy is high from the cycle after an accepted
// start through the done cycle; done pulses for exactly one cycle with err/b valid and held.
module modinv_bin
    import modinv_pkg::*;
#(
    parameter int W = MODINV_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  p,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  b,
    output modinv_state_e state
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    modinv_state_e st;
    logic [W-1:0]  u, v, x1, x2, pm;
    logic [W-1:0]  h1, h2;
    logic [W-1:0]  d12, d21, s12, s21;
    logic [W-1:0]  u_load;

    assign state = st;

    modinv_half #(.W(W)) u_half1 (.x(x1), .p(pm), .y(h1));
    modinv_half #(.W(W)) u_half2 (.x(x2), .p(pm), .y(h2));

    // Differences wrap in W bits; adding p back lands exactly in [0, p-1].
    assign d12 = x1 - x2;
    assign d21 = x2 - x1;
    assign s12 = (x1 >= x2) ? d12 : d12 + pm;
    assign s21 = (x2 >= x1) ? d21 : d21 + pm;

`ifdef MODINV_ARGCHK_EN
    logic args_ok;
    // A rejected argument loads u=0, so CHK reports err=1 with b=0 on the following cycle.
    assign args_ok = p[0] && (p[W-1:1] != '0) && (a != '0) && (a < p);
    assign u_load  = args_ok ? a : '0;
`else
    assign u_load  = a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            u    <= '0;
            v    <= '0;
            x1   <= '0;
            x2   <= '0;
            pm   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            b    <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        u    <= u_load;
                        v    <= p;
                        x1   <= ONE;
                        x2   <= '0;
                        pm   <= p;
                        busy <= 1'b1;
                        st   <= CHK;
                    end
                end
                CHK: begin
                    if (u == '0 || v == '0) begin
                        err  <= 1'b1;
                        b    <= '0;
                        done <= 1'b1;
                        st   <= DONE;
                    end else if (u == ONE || v == ONE) begin
                        err  <= 1'b0;
                        b    <= (u == ONE) ? x1 : x2;
                        done <= 1'b1;
                        st   <= DONE;
                    end else if (!u[0]) begin
                        st <= HALVE_U;
                    end else if (!v[0]) begin
                        st <= HALVE_V;
                    end else begin
                        st <= SUB;
                    end
                end
                HALVE_U: begin
                    u  <= u >> 1;
                    x1 <= h1;
                    // u[1] is the LSB after this shift; skip HALVE_V when v is already odd.
                    if (u[1]) begin
                        st <= v[0] ? SUB : HALVE_V;
                    end
                end
                HALVE_V: begin
                    v  <= v >> 1;
                    x2 <= h2;
                    if (v[1]) begin
                        st <= SUB;
                    end
                end
                SUB: begin
                    if (u >= v) begin
                        u  <= u - v;
                        x1 <= s12;
                    end else begin
                        v  <= v - u;
                        x2 <= s21;
                    end
                    st <= CHK;
                end
                DONE: begin
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
